// File: rtl/interrupt_sequencer_if.sv
// Signal bundle between the interrupt sequencer and the CPU core: request/strobe
// inputs toward the sequencer, stack/vector control outputs back to the core.
interface interrupt_sequencer_if;
  logic        NMI_L;
  logic        IRQ_L;
  logic        RDY;
  logic        T1;
  logic        I_flag;
  logic        brk_op;
  logic        nmiPending;
  logic        irqPending;
  logic        resPending;
  logic        nmiHandled;
  logic        irqHandled;
  logic        resHandled;
  logic        int_active;
  logic [2:0]  int_state;
  logic [15:0] vec_addr;
  logic        O_ADL0;
  logic        O_ADL1;
  logic        O_ADL2;
  logic        push_en;
  logic        sp_dec;
  logic        write_inhibit;
  logic        set_I;
  logic        brk_flag;
  logic        seq_done;

  modport slave (
    input  NMI_L, IRQ_L, RDY, T1, I_flag, brk_op,
    output nmiPending, irqPending, resPending,
    output nmiHandled, irqHandled, resHandled,
    output int_active, int_state, vec_addr, O_ADL0, O_ADL1, O_ADL2,
    output push_en, sp_dec, write_inhibit, set_I, brk_flag, seq_done
  );

  modport master (
    output NMI_L, IRQ_L, RDY, T1, I_flag, brk_op,
    input  nmiPending, irqPending, resPending,
    input  nmiHandled, irqHandled, resHandled,
    input  int_active, int_state, vec_addr, O_ADL0, O_ADL1, O_ADL2,
    input  push_en, sp_dec, write_inhibit, set_I, brk_flag, seq_done
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// 6502-style interrupt sequencer: latches RES/NMI/IRQ/BRK requests and steps the
// seven-cycle push-and-vector sequence, with NMI hijack of IRQ/BRK.
module interrupt_sequencer #(
  parameter logic [15:0] NMI_VEC = 16'hFFFA,
  parameter logic [15:0] RES_VEC = 16'hFFFC,
  parameter logic [15:0] IRQ_VEC = 16'hFFFE
) (
  input  logic phi2,
  input  logic RES_L,
  interrupt_sequencer_if.slave bus
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_DUMMY    = 3'd1;
  localparam logic [2:0] S_PUSH_PCH = 3'd2;
  localparam logic [2:0] S_PUSH_PCL = 3'd3;
  localparam logic [2:0] S_PUSH_P   = 3'd4;
  localparam logic [2:0] S_VEC_LO   = 3'd5;
  localparam logic [2:0] S_VEC_HI   = 3'd6;

  localparam logic [1:0] SRC_RES = 2'd0;
  localparam logic [1:0] SRC_NMI = 2'd1;
  localparam logic [1:0] SRC_IRQ = 2'd2;
  localparam logic [1:0] SRC_BRK = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [1:0]  src_q, src_d;
  logic        brk_q, brk_d;
  logic        res_pend_q, res_pend_d;
  logic        nmi_pend_q, nmi_pend_d;
  logic        nmi_reg_q, nmi_reg_d;
  logic        irq_reg_q, irq_reg_d;

  logic        nmi_edge;
  logic        irq_pend;
  logic        in_push;
  logic        pre_vec;
  logic        in_vec;
  logic        done;
  logic [15:0] vec_base;
  logic [15:0] vec_addr;

  // RDY is a stall qualifier: a cycle in DUMMY/VEC_LO/VEC_HI (reads) only
  // advances when RDY=1; push cycles are writes and always advance.
  always_comb begin
    nmi_edge   = nmi_reg_q & ~bus.NMI_L;
    irq_pend   = irq_reg_q & ~bus.I_flag;
    in_push    = (state_q == S_PUSH_PCH) || (state_q == S_PUSH_PCL) || (state_q == S_PUSH_P);
    pre_vec    = in_push || (state_q == S_DUMMY);
    in_vec     = (state_q == S_VEC_LO) || (state_q == S_VEC_HI);
    done       = (state_q == S_VEC_HI) && bus.RDY;

    state_d    = state_q;
    src_d      = src_q;
    brk_d      = brk_q;
    res_pend_d = res_pend_q;
    nmi_pend_d = nmi_pend_q;
    nmi_reg_d  = bus.NMI_L;
    irq_reg_d  = ~bus.IRQ_L;

    // A fresh NMI edge steals a maskable sequence until the vector fetch begins.
    if (nmi_edge && pre_vec && ((src_q == SRC_IRQ) || (src_q == SRC_BRK)))
      src_d = SRC_NMI;

    case (state_q)
      S_IDLE: begin
        if (res_pend_q) begin
          state_d = S_DUMMY;
          src_d   = SRC_RES;
          brk_d   = 1'b0;
        end else if (bus.T1 && bus.RDY) begin
          if (nmi_pend_q || nmi_edge) begin
            state_d = S_DUMMY;
            src_d   = SRC_NMI;
            brk_d   = 1'b0;
          end else if (irq_pend) begin
            state_d = S_DUMMY;
            src_d   = SRC_IRQ;
            brk_d   = 1'b0;
          end else if (bus.brk_op) begin
            state_d = S_DUMMY;
            src_d   = SRC_BRK;
            brk_d   = 1'b1;
          end
        end
      end
      S_DUMMY:    if (bus.RDY) state_d = S_PUSH_PCH;
      S_PUSH_PCH: state_d = S_PUSH_PCL;
      S_PUSH_PCL: state_d = S_PUSH_P;
      S_PUSH_P:   state_d = S_VEC_LO;
      S_VEC_LO:   if (bus.RDY) state_d = S_VEC_HI;
      S_VEC_HI: begin
        if (bus.RDY) begin
          state_d = S_IDLE;
          if (src_q == SRC_RES) res_pend_d = 1'b0;
        end
      end
      default:    state_d = S_IDLE;
    endcase

    // Entering VEC_LO services the NMI; a later edge stays latched for next time.
    if ((state_q == S_PUSH_P) && (src_d == SRC_NMI))
      nmi_pend_d = 1'b0;
    else if (nmi_edge)
      nmi_pend_d = 1'b1;
  end

  always_comb begin
    case (src_q)
      SRC_RES: vec_base = RES_VEC;
      SRC_NMI: vec_base = NMI_VEC;
      default: vec_base = IRQ_VEC;
    endcase
    if (state_q == S_VEC_LO)      vec_addr = vec_base;
    else if (state_q == S_VEC_HI) vec_addr = vec_base + 16'd1;
    else                          vec_addr = 16'h0000;
  end

  always_ff @(posedge phi2 or negedge RES_L) begin
    if (!RES_L) begin
      state_q    <= S_IDLE;
      src_q      <= SRC_RES;
      brk_q      <= 1'b0;
      res_pend_q <= 1'b1;
      nmi_pend_q <= 1'b0;
      nmi_reg_q  <= 1'b1;
      irq_reg_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      brk_q      <= brk_d;
      res_pend_q <= res_pend_d;
      nmi_pend_q <= nmi_pend_d;
      nmi_reg_q  <= nmi_reg_d;
      irq_reg_q  <= irq_reg_d;
    end
  end

  assign bus.nmiPending    = nmi_pend_q;
  assign bus.irqPending    = irq_pend;
  assign bus.resPending    = res_pend_q;
  assign bus.nmiHandled    = done && (src_q == SRC_NMI);
  assign bus.irqHandled    = done && ((src_q == SRC_IRQ) || (src_q == SRC_BRK));
  assign bus.resHandled    = done && (src_q == SRC_RES);
  assign bus.seq_done      = done;
  assign bus.int_active    = (state_q != S_IDLE);
  assign bus.int_state     = state_q;
  assign bus.vec_addr      = vec_addr;
  // ADL pull-downs drive the low address bits toward the vector inside VEC states only.
  assign bus.O_ADL0        = in_vec & ~vec_addr[0];
  assign bus.O_ADL1        = in_vec & ~vec_addr[1];
  assign bus.O_ADL2        = in_vec & ~vec_addr[2];
  assign bus.push_en       = in_push;
  assign bus.sp_dec        = in_push;
  assign bus.write_inhibit = in_push && (src_q == SRC_RES);
  assign bus.set_I         = (state_q == S_VEC_LO);
  assign bus.brk_flag      = (state_q == S_PUSH_P) && brk_q;

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 Parameter NMI_VEC, default 16'hFFFA: NMI vector low-byte address.
REQ-002 Parameter RES_VEC, default 16'hFFFC: reset vector low-byte address.
REQ-003 Parameter IRQ_VEC, default 16'hFFFE: IRQ/BRK vector low-byte address.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports as follows:
- phi2  in  1  sole clock; all state updates on rising edge
- RES_L  in  1  asynchronous active-low reset
- NMI_L  in  1  NMI request, falling-edge sensitive
- IRQ_L  in  1  IRQ request, level, active low
- RDY  in  1  ready; 0 stalls read cycles
- T1  in  1  instruction-boundary strobe from FSM
- I_flag  in  1  status I bit
- brk_op  in  1  current opcode is BRK (valid with T1)
- nmiPending / irqPending / resPending  out  1 each  latched requests
- nmiHandled / irqHandled / resHandled  out  1 each  one-cycle acknowledge
- int_active  out  1  sequence in progress (state != IDLE)
- int_state  out  3  current state encoding
- vec_addr  out  16  vector fetch address, 0 outside VEC states
- O_ADL0, O_ADL1, O_ADL2  out  1 each  ADL bit pull-downs
- push_en  out  1  stack push cycle
- sp_dec  out  1  decrement stack pointer this cycle
- write_inhibit  out  1  force read during push cycles
- set_I  out  1  set I flag
- brk_flag  out  1  B bit value for pushed P
- seq_done  out  1  one-cycle end-of-sequence pulse

Function
REQ-005 The block SHALL use states IDLE=0, DUMMY=1, PUSH_PCH=2, PUSH_PCL=3, PUSH_P=4, VEC_LO=5, VEC_HI=6, and SHALL return to IDLE from any other encoding.
REQ-006 NMI_L SHALL be registered each cycle; a previous 1 followed by a current 0 SHALL set nmiPending, which SHALL be cleared on entry to VEC_LO when the source is NMI.
REQ-007 irqPending SHALL equal registered ~IRQ_L AND ~I_flag, with no latching.
REQ-008 In IDLE with T1=1 and RDY=1, the block SHALL capture a source with priority RES > NMI > IRQ > BRK and go to DUMMY; with no source it SHALL stay in IDLE.
REQ-009 The sequence SHALL be DUMMY -> PUSH_PCH -> PUSH_PCL -> PUSH_P -> VEC_LO -> VEC_HI -> IDLE, one state per cycle, for a total of 6 cycles after capture.
REQ-010 Read states (DUMMY, VEC_LO, VEC_HI) SHALL hold when RDY=0; push states SHALL ignore RDY.
REQ-011 push_en and sp_dec SHALL be 1 in the three push states; write_inhibit SHALL be 1 in those states only when the source is RES, so that SP still decrements.
REQ-012 brk_flag SHALL be 1 in PUSH_P only for source BRK, and 0 otherwise.
REQ-013 vec_addr SHALL be base in VEC_LO and base+1 in VEC_HI; O_ADLn SHALL equal ~vec_addr[n] in VEC states and 0 elsewhere.
REQ-014 set_I SHALL be 1 in VEC_LO.
REQ-015 The matching Handled output and seq_done SHALL pulse for one cycle in VEC_HI when it completes (RDY=1).
REQ-016 NMI hijack: a new NMI edge while the source is IRQ or BRK, in any state before VEC_LO, SHALL switch the source to NMI; brk_flag SHALL keep the original BRK value.
REQ-017 An NMI edge at or after VEC_LO SHALL remain pending and be serviced at the next qualifying T1.
REQ-018 IRQ deassertion mid-sequence SHALL NOT abort the sequence.
REQ-019 T1 outside IDLE SHALL be ignored.

Reset
REQ-020 RES_L=0 SHALL asynchronously force IDLE, resPending=1, nmiPending=0, registered NMI_L=1, and all other outputs 0, including mid-sequence.
REQ-021 On the first phi2 edge with RES_L=1 and resPending=1, the block SHALL enter DUMMY with source RES without waiting for T1; resPending SHALL clear in VEC_HI.

Verification
REQ-022 Release RES_L, hold RDY=1 -> DUMMY on edge 1, three push cycles with write_inhibit=1 and sp_dec=1, vec_addr FFFC then FFFD, resHandled and seq_done pulse, IDLE on edge 7.
REQ-023 IRQ_L=0, I_flag=0, T1 pulse -> vec_addr FFFE/FFFF, brk_flag=0, set_I in VEC_LO, irqHandled pulse; repeating with I_flag=1 -> no sequence.
REQ-024 BRK (brk_op=1, T1) with an NMI falling edge during PUSH_PCL -> brk_flag=1 in PUSH_P, vec_addr FFFA/FFFB, nmiHandled pulse, irqHandled never pulses.
REQ-025 RDY=0 for 3 cycles in VEC_LO and for 2 cycles in PUSH_PCH -> sequence is 3 cycles longer; the push stall is ignored.
REQ-026 RES_L asserted in PUSH_P of an IRQ sequence -> immediate IDLE with outputs 0; after release, reset sequence fetches FFFC.
REQ-027 NMI_L held low across two T1 strobes -> exactly one NMI sequence; a second falling edge during VEC_HI -> serviced at the next T1.
